mio_bus_responder: RTL and testbench
====================================

MIO_BUS_RESPONDER -- requirements
Module: mio_bus_responder

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 10, meaning RAM word-address width (1024 words).
REQ-002 The block SHALL have parameter IO_W, default 16, meaning LED/switch register width.
REQ-003 The block SHALL have one clock and asynchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-004 Ports, CPU side: cpu_mio  input  1  request, held high until mio_ready seen; mem_rw  input  1  1=write, 0=read; addr  input  32  byte address; wdata  input  32  write data; rdata  output  32  read data; mio_ready  output  1  one-cycle completion strobe; bus_err  output  1  unmapped-access flag, valid with mio_ready.
REQ-005 Ports, RAM side (synchronous RAM, 1-cycle read latency): ram_en  output  1; ram_we  output  1; ram_addr  output  RAM_AW  word address; ram_din  output  32; ram_dout  input  32.
REQ-006 Ports, IO side: sw_in  input  IO_W  switch inputs; led_out  output  IO_W  LED register.

Function
REQ-007 Address map SHALL be: RAM 0x0000_0000..(4*2^RAM_AW-1); LED 0xF000_0000 (RW); SW 0xF000_0004 (RO); CNT 0xF000_0008 (RW); all else unmapped.
REQ-008 addr[1:0] SHALL be ignored; all accesses are full-word.
REQ-009 FSM states SHALL be IDLE, ACCESS, WAIT, RESP.
REQ-010 IDLE: when cpu_mio=1, latch addr, wdata, mem_rw and go to ACCESS; else stay.
REQ-011 ACCESS: for RAM, drive ram_en=1, ram_addr=latched addr[RAM_AW+1:2], ram_din=latched wdata, ram_we=latched mem_rw; ram_en/ram_we SHALL be 0 in every other state.
REQ-012 ACCESS: register writes (LED, CNT) SHALL take effect at the ACCESS->next edge; writes to SW or unmapped addresses are ignored.
REQ-013 ACCESS: RAM read goes to WAIT; all other accesses register rdata (LED zero-extended, SW zero-extended, CNT current value, writes/unmapped 0) and go to RESP.
REQ-014 WAIT: capture ram_dout into rdata, go to RESP.
REQ-015 RESP: mio_ready=1 for exactly this cycle, rdata held valid, bus_err=1 if latched address unmapped; go to IDLE.
REQ-016 Latency from request-sampling edge k: RAM read mio_ready high in cycle k+3; all other accesses in cycle k+2.
REQ-017 If cpu_mio is still high in IDLE after RESP, it SHALL be accepted as a new request (requester must drop it after seeing ready).
REQ-018 Inputs SHALL be ignored outside IDLE; changes mid-transaction do not affect the latched request.
REQ-019 CNT SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF->0; a CNT write loads wdata instead of incrementing that cycle.
REQ-020 rdata SHALL hold its last value outside RESP; bus_err and mio_ready SHALL be 0 outside RESP.

Reset
REQ-021 On rst: state=IDLE, mio_ready=0, bus_err=0, rdata=0, led_out=0, CNT=0, ram_en=0, ram_we=0, latched request cleared.
REQ-022 Reset asserted mid-transaction SHALL abandon it: no ready, no register write; RAM write occurs only if the ACCESS cycle completed before rst.

Structure
REQ-023 Package mio_pkg SHALL hold the state enum, address-map constants, and region-code typedef (RAM, LED, SW, CNT, NONE).
REQ-024 One sub-module mio_addr_decode (combinational addr -> region code) SHALL be used; FSM, registers and counter stay in the top.

Verification
REQ-025 RAM write 0x1234_5678 to 0x10 then read 0x10 -> ram_we one cycle with ram_addr=4; read ready at k+3 with rdata=0x1234_5678, bus_err=0.
REQ-026 Write 0x0000_A5A5 to 0xF000_0000, read back; read SW with sw_in=0x3C3C -> led_out=0xA5A5, rdata=0x0000_A5A5; SW read rdata=0x0000_3C3C, ready at k+2.
REQ-027 Write 0xFFFF_FFFE to CNT, read 3 cycles later -> counter wraps through 0; rdata equals value at ACCESS cycle.
REQ-028 Read/write 0x8000_0000 -> ready at k+2, bus_err=1, rdata=0, no RAM or register change.
REQ-029 Assert rst during ACCESS of LED write, and cpu_mio held high across two back-to-back reads -> no ready, led_out=0 after reset; back-to-back reads each produce exactly one ready pulse.

Source files
------------

// File: rtl/mio_pkg.sv
// mio_pkg: shared FSM states, region codes and IO address map for the MIO bus responder.
package mio_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;
    typedef enum logic [2:0] {R_RAM, R_LED, R_SW, R_CNT, R_NONE} region_e;
    localparam logic [31:0] LED_ADDR = 32'hF000_0000;
    localparam logic [31:0] SW_ADDR  = 32'hF000_0004;
    localparam logic [31:0] CNT_ADDR = 32'hF000_0008;
endpackage

// File: rtl/mio_addr_decode.sv
// mio_addr_decode: maps a word address (byte offset bits dropped) onto a bus region.
module mio_addr_decode import mio_pkg::*; #(
    parameter int RAM_AW = 10
) (
    input  logic [31:2] addr_i,
    output region_e     region_o
);
    always_comb
        region_o = (addr_i[31:RAM_AW+2] == '0)  ? R_RAM :
                   (addr_i == LED_ADDR[31:2])   ? R_LED :
                   (addr_i == SW_ADDR[31:2])    ? R_SW  :
                   (addr_i == CNT_ADDR[31:2])   ? R_CNT : R_NONE;
endmodule

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: CPU memory/IO responder with synchronous RAM, LED/switch
// registers and a free-running cycle counter.
module mio_bus_responder import mio_pkg::*; #(
    parameter int RAM_AW = 10,
    parameter int IO_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mio,
    input  logic              mem_rw,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    output logic              bus_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [IO_W-1:0]   sw_in,
    output logic [IO_W-1:0]   led_out
);
    state_e            state_q;
    region_e           region_q, region_in;
    logic              we_q, ready_q, err_q, ram_en_q, ram_we_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [31:0]       wdata_q, rdata_q, rdata_d, cnt_q, cnt_d;
    logic [IO_W-1:0]   led_q;

    mio_addr_decode #(.RAM_AW(RAM_AW)) u_decode (
        .addr_i   (addr[31:2]),
        .region_o (region_in)
    );

    always_comb begin
        rdata_d = we_q                 ? '0            :
                  (region_q == R_LED)  ? 32'(led_q)    :
                  (region_q == R_SW)   ? 32'(sw_in)    :
                  (region_q == R_CNT)  ? cnt_q         : '0;
        cnt_d   = (state_q == S_ACCESS && we_q && region_q == R_CNT) ? wdata_q : cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            region_q   <= R_NONE;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ram_addr_q <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            led_q      <= '0;
            cnt_q      <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: if (cpu_mio) begin
                    region_q   <= region_in;
                    we_q       <= mem_rw;
                    wdata_q    <= wdata;
                    ram_addr_q <= addr[RAM_AW+1:2];
                    ram_en_q   <= (region_in == R_RAM);
                    ram_we_q   <= (region_in == R_RAM) && mem_rw;
                    state_q    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (we_q && region_q == R_LED)
                        led_q <= wdata_q[IO_W-1:0];
                    if (region_q == R_RAM && !we_q) begin
                        state_q <= S_WAIT;
                    end else begin
                        rdata_q <= rdata_d;
                        ready_q <= 1'b1;
                        err_q   <= (region_q == R_NONE);
                        state_q <= S_RESP;
                    end
                end
                S_WAIT: begin
                    rdata_q <= ram_dout;
                    ready_q <= 1'b1;
                    state_q <= S_RESP;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign mio_ready = ready_q;
    assign bus_err   = err_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = wdata_q;
    assign led_out   = led_q;
endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: randomized transactions against a transaction-level model
// of the responder, with a per-cycle output compare and a few literal anchors.
module tb_mio_bus_responder;
    localparam logic [31:0] LED = 32'hF000_0000;
    localparam logic [31:0] SW  = 32'hF000_0004;
    localparam logic [31:0] CNT = 32'hF000_0008;
    localparam logic [31:0] RAM_BYTES = 32'h0000_1000;

    logic        clk = 1'b0, rst, cpu_mio, mem_rw;
    logic [31:0] addr, wdata, rdata, ram_din, ram_dout;
    logic        mio_ready, bus_err, ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] sw_in, led_out;

    mio_bus_responder dut (
        .clk(clk), .rst(rst), .cpu_mio(cpu_mio), .mem_rw(mem_rw), .addr(addr),
        .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready), .bus_err(bus_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .sw_in(sw_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] seed(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h5A5A_0000;
    endfunction

    // Environment RAM: synchronous, read-first, one-cycle latency
    logic [31:0] ram_arr [1024];
    bit          ram_v   [1024];
    always @(posedge clk) if (ram_en) begin
        if (ram_we) begin
            ram_arr[ram_addr] <= ram_din;
            ram_v[ram_addr]   <= 1'b1;
        end
        ram_dout <= ram_v[ram_addr] ? ram_arr[ram_addr] : seed(int'(ram_addr));
    end

    int total = 0, bad = 0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h cyc=%0d", n, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          rdy;
        int          acc;
        bit          ram;
        bit          we;
        logic [9:0]  word;
        logic [31:0] din;
        logic [31:0] rdata;
        bit          err;
        logic [15:0] led;
    } exp_t;
    exp_t q[$];

    logic [31:0] mem_m [1024];
    logic [31:0] cnt_base;
    int          cnt_t, idle_from;
    logic [15:0] drv_led;

    logic [31:0] rdata_m;
    logic [15:0] led_m;
    always @(negedge clk) begin : cmp
        bit hit, en;
        if (rst) begin
            q.delete();
            led_m   = '0;
            rdata_m = '0;
        end else begin
            hit = q.size() > 0 && q[0].rdy == cyc;
            en  = q.size() > 0 && q[0].ram && q[0].acc == cyc;
            chk("ram_en", 32'(ram_en), 32'(en));
            chk("ram_we", 32'(ram_we), 32'(en && q[0].we));
            if (en) begin
                chk("ram_addr", 32'(ram_addr), 32'(q[0].word));
                if (q[0].we) chk("ram_din", ram_din, q[0].din);
            end
            if (hit) begin
                led_m   = q[0].led;
                rdata_m = q[0].rdata;
                chk("ready", 32'(mio_ready), 32'd1);
                chk("bus_err", 32'(bus_err), 32'(q[0].err));
                void'(q.pop_front());
            end else begin
                chk("ready_idle", 32'(mio_ready), 32'd0);
                chk("err_idle", 32'(bus_err), 32'd0);
            end
            chk("rdata", rdata, rdata_m);
            chk("led_out", 32'(led_out), 32'(led_m));
        end
    end

    task automatic release_rst();
        rst       = 1'b0;
        cnt_base  = '0;
        cnt_t     = cyc;
        idle_from = cyc;
        drv_led   = '0;
    endtask

    task automatic idle(input int n);
        cpu_mio = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Issues one request at the current falling edge and returns at the ready cycle,
    // leaving cpu_mio high so the caller may chain a held request.
    task automatic issue(input bit rw, input logic [31:0] a, input logic [31:0] d, output int r);
        exp_t        e;
        int          c;
        bit          ok;
        logic [31:0] w;
        mem_rw = rw; addr = a; wdata = d; cpu_mio = 1'b1;
        c = (cyc > idle_from) ? cyc : idle_from;
        w = a & ~32'h3;
        e.acc = c + 1; e.we = rw; e.word = a[11:2]; e.din = d;
        e.ram = 0; e.err = 0; e.rdata = '0; e.rdy = c + 2;
        if (a < RAM_BYTES) begin
            e.ram = 1;
            if (rw) mem_m[a[11:2]] = d;
            else begin
                e.rdata = mem_m[a[11:2]];
                e.rdy   = c + 3;
            end
        end else if (w == LED) begin
            if (rw) drv_led = d[15:0];
            else e.rdata = {16'h0, drv_led};
        end else if (w == SW) begin
            if (!rw) e.rdata = {16'h0, sw_in};
        end else if (w == CNT) begin
            if (rw) begin
                cnt_base = d;
                cnt_t    = c + 2;
            end else e.rdata = cnt_base + 32'(c + 1 - cnt_t);
        end else e.err = 1;
        e.led = drv_led;
        q.push_back(e);
        idle_from = e.rdy + 1;
        ok = 0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (mio_ready) ok = 1;
            else if (cyc > c) begin
                addr   = $urandom;
                wdata  = $urandom;
                mem_rw = 1'($urandom);
            end
        end
        chk("ready_timeout", 32'(ok), 32'd1);
        r = cyc;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int s, r, r1, r2, sel;
        bit rw;
        logic [31:0] a;
        rst = 1'b1; cpu_mio = 1'b0; mem_rw = 1'b0; addr = '0; wdata = '0; sw_in = '0;
        for (int i = 0; i < 1024; i++) mem_m[i] = seed(i);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(mio_ready), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        release_rst();
        idle(2);

        s = cyc; issue(1, 32'h10, 32'h1234_5678, r); chk("ram_wr_lat", 32'(r - s), 32'd2); idle(1);
        s = cyc; issue(0, 32'h10, 32'h0, r);
        chk("ram_rd_lat", 32'(r - s), 32'd3);
        chk("ram_rd_lit", rdata, 32'h1234_5678);
        chk("ram_rd_err", 32'(bus_err), 32'd0);
        idle(1);

        issue(1, LED, 32'h0000_A5A5, r); chk("led_lit", 32'(led_out), 32'h0000_A5A5); idle(1);
        issue(0, LED, 32'h0, r); chk("led_rd_lit", rdata, 32'h0000_A5A5); idle(1);
        sw_in = 16'h3C3C;
        s = cyc; issue(0, SW, 32'h0, r);
        chk("sw_lat", 32'(r - s), 32'd2);
        chk("sw_rd_lit", rdata, 32'h0000_3C3C);
        idle(1);

        issue(1, CNT, 32'hFFFF_FFFE, r); idle(2);
        issue(0, CNT, 32'h0, r); chk("cnt_wrap_lit", rdata, 32'h0000_0001); idle(1);

        s = cyc; issue(0, 32'h8000_0000, 32'h0, r);
        chk("unm_lat", 32'(r - s), 32'd2);
        chk("unm_err", 32'(bus_err), 32'd1);
        chk("unm_rdata", rdata, 32'd0);
        issue(1, 32'h8000_0000, 32'hDEAD_BEEF, r); chk("unm_wr_err", 32'(bus_err), 32'd1); idle(1);
        chk("unm_led_kept", 32'(led_out), 32'h0000_A5A5);
        issue(0, 32'h10, 32'h0, r); chk("ram_kept", rdata, 32'h1234_5678); idle(1);

        cpu_mio = 1'b1; mem_rw = 1'b1; addr = LED; wdata = 32'h0000_FFFF;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cpu_mio = 1'b0;
        release_rst();
        idle(3);
        chk("rst_abandon_led", 32'(led_out), 32'd0);
        chk("rst_abandon_rdy", 32'(mio_ready), 32'd0);

        sw_in = 16'h1111;
        issue(0, LED, 32'h0, r1);
        issue(0, SW, 32'h0, r2);
        chk("b2b_gap", 32'(r2 - r1), 32'd3);
        chk("b2b_rdata", rdata, 32'h0000_1111);
        idle(1);

        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 6));
            rw  = 1'($urandom);
            a = (sel == 0) ? {20'h0, 6'($urandom), 6'h0} | 32'($urandom_range(0, 63)) :
                (sel == 1) ? 32'h0000_0FFC :
                (sel == 2) ? LED :
                (sel == 3) ? SW :
                (sel == 4) ? CNT :
                (sel == 5) ? 32'h0000_1000 :
                             (($urandom & 32'h0FFF_FFFF) | 32'h1000_0000);
            a = (sel >= 1 && sel <= 4) ? (a | 32'($urandom_range(0, 3))) : a;
            sw_in = 16'($urandom);
            issue(rw, a, $urandom, r);
            idle(int'($urandom_range(0, 2)));
        end

        idle(5);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
